// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter (CPU port A, locked-burst capable port B)
//   clk, reset            : single clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata, a_gnt/a_rvalid/a_rdata : CPU port
//   b_req/b_we/b_lock/b_addr/b_wdata, b_gnt/b_rvalid/b_rdata : second port, b_lock asks for a burst
//   m_addr/m_wdata/m_write/m_read, m_rdata : data memory (combinational read data)
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_write,
    output logic        m_read,
    input  logic [15:0] m_rdata
);
    localparam int SW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    localparam int BW = ($clog2(BURST_MAX + 1) > 1) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [BW-1:0] BEATS_MAX = BW'(BURST_MAX);

    typedef enum logic {ARB, BURST} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          a_first_q, a_first_d;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [15:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic          b_wins;

    always_comb begin
        // a_first_q gives A the cycle right after a full-length burst, even if B is starved
        b_wins = b_req && (!a_req || (starve_q == STARVE_MAX && !a_first_q));
        b_gnt = (state_q == BURST) ? b_req : b_wins;
        a_gnt = (state_q == ARB) && a_req && !b_wins;
        m_write = (a_gnt && a_we) || (b_gnt && b_we);
        m_read = (a_gnt && !a_we) || (b_gnt && !b_we);
        m_addr = a_gnt ? a_addr : b_gnt ? b_addr : '0;
        m_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
        starve_d = !(b_req && !b_gnt) ? '0 : (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        a_rdata_d = a_rvalid_d ? m_rdata : a_rdata_q;
        b_rdata_d = b_rvalid_d ? m_rdata : b_rdata_q;
        state_d = state_q;
        burst_d = burst_q;
        a_first_d = 1'b0;
        if (state_q == ARB) begin
            if (b_gnt && b_lock) begin
                // a one-beat burst limit is exhausted by the entry grant itself
                state_d = (BURST_MAX > 1) ? BURST : ARB;
                burst_d = (BURST_MAX > 1) ? BW'(1) : '0;
                a_first_d = (BURST_MAX <= 1);
            end
        end else if (!b_req || !b_lock) begin
            state_d = ARB;
            burst_d = '0;
        end else if (burst_q + BW'(1) == BEATS_MAX) begin
            state_d = ARB;
            burst_d = '0;
            a_first_d = 1'b1;
        end else begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            starve_q <= '0;
            burst_q <= '0;
            a_first_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            starve_q <= starve_d;
            burst_q <= burst_d;
            a_first_q <= a_first_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against a rule-level model
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, m_write, m_read;
    logic [15:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_read(m_read), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return (i == 2) ? 16'h1234 : 16'((i * 257) ^ 16'h5A5A);
    endfunction

    assign m_rdata = m_read ? mem[m_addr[8:1]] : 16'h0000;

    always @(posedge clk) begin
        if (m_write) mem[m_addr[8:1]] <= m_wdata;
        else if (pre_we) mem[pre_idx] <= init_word(int'(pre_idx));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1;
        pre_we = 1;
        for (int i = 0; i < 256; i++) begin
            pre_idx = 8'(i);
            ref_mem[i] = init_word(i);
            tick();
        end
        pre_we = 0;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, m_read, m_write} !== 6'b0 || a_rdata !== 0 || b_rdata !== 0)
            begin errors++; $display("FAIL reset_idle: got gnt=%b%b rv=%b%b rd=%h/%h expected all zero", a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata); end
        a_req = 1; b_req = 1;
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10)
            begin errors++; $display("FAIL reset_both_req: got %b%b expected 10", a_gnt, b_gnt); end
        a_req = 0;
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01)
            begin errors++; $display("FAIL reset_b_only: got %b%b expected 01", a_gnt, b_gnt); end
        idle();
        reset = 0;
        tick();
    endtask

    task automatic test_single_read;
        idle();
        a_req = 1; a_addr = 16'h0004;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10)
            begin errors++; $display("FAIL read_gnt: got %b%b expected 10", a_gnt, b_gnt); end
        checks++;
        if (m_read !== 1 || m_write !== 0 || m_addr !== 16'h0004)
            begin errors++; $display("FAIL read_bus: got rd=%b wr=%b addr=%h expected 1 0 0004", m_read, m_write, m_addr); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'h1234 || b_gnt !== 0)
            begin errors++; $display("FAIL read_return: got rv=%b rdata=%h bgnt=%b expected 1 1234 0", a_rvalid, a_rdata, b_gnt); end
        tick();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 0 || a_rdata !== 16'h1234 || b_rvalid !== 0)
            begin errors++; $display("FAIL read_hold: got rv=%b rdata=%h brv=%b expected 0 1234 0", a_rvalid, a_rdata, b_rvalid); end
    endtask

    task automatic test_simultaneous;
        idle();
        tick();
        a_req = 1; b_req = 1; b_addr = 16'h0002;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10)
            begin errors++; $display("FAIL simul_gnt: got %b%b expected 10", a_gnt, b_gnt); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (dut.starve_q !== 1 || a_rvalid !== 1 || a_rdata !== ref_mem[0])
            begin errors++; $display("FAIL simul_starve: got starve=%0d rv=%b rdata=%h expected 1 1 %h", dut.starve_q, a_rvalid, a_rdata, ref_mem[0]); end
    endtask

    task automatic test_fairness;
        logic prev_b = 0;
        idle();
        tick();
        a_req = 1; a_addr = 16'h0000;
        b_req = 1; b_addr = 16'h0002;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== ((c % 5 == 4) ? 2'b01 : 2'b10))
                begin errors++; $display("FAIL fair_gnt c=%0d: got %b%b expected %b", c, a_gnt, b_gnt, (c % 5 == 4) ? 2'b01 : 2'b10); end
            if (c > 0) begin
                checks++;
                if (b_rvalid !== prev_b || (prev_b && b_rdata !== ref_mem[1]))
                    begin errors++; $display("FAIL fair_rvalid c=%0d: got rv=%b rdata=%h expected %b %h", c, b_rvalid, b_rdata, prev_b, ref_mem[1]); end
            end
            prev_b = (c % 5 == 4);
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_burst;
        logic [1:0] exp_q[$];
        int beats = 0;
        repeat (4) exp_q.push_back(2'b10);
        repeat (8) exp_q.push_back(2'b01);
        repeat (4) exp_q.push_back(2'b10);
        repeat (2) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        idle();
        a_req = 1; a_addr = 16'h0006;
        b_req = 1; b_we = 1; b_lock = 1; b_addr = 16'h0010; b_wdata = 16'hBEEF;
        foreach (exp_q[c]) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== exp_q[c] || b_rvalid !== 0)
                begin errors++; $display("FAIL burst_gnt c=%0d: got %b%b brv=%b expected %b brv=0", c, a_gnt, b_gnt, b_rvalid, exp_q[c]); end
            if (b_gnt) beats++;
            tick();
            if (beats == 10) b_req = 0;
        end
        idle();
        tick();
        ref_mem[8] = 16'hBEEF;
        checks++;
        if (mem[8] !== 16'hBEEF || beats !== 10)
            begin errors++; $display("FAIL burst_data: got mem=%h beats=%0d expected beef 10", mem[8], beats); end
    endtask

    task automatic test_reset_in_burst;
        idle();
        b_req = 1; b_lock = 1; b_addr = 16'h0004;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01)
            begin errors++; $display("FAIL rib_enter: got %b%b expected 01", a_gnt, b_gnt); end
        tick();
        a_req = 1; a_addr = 16'h0000;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01)
            begin errors++; $display("FAIL rib_priority: got %b%b expected 01", a_gnt, b_gnt); end
        tick();
        reset = 1;
        #1;
        checks++;
        if (b_rvalid !== 0 || dut.burst_q !== 0 || dut.starve_q !== 0 || {a_gnt, b_gnt} !== 2'b10)
            begin errors++; $display("FAIL rib_reset: got brv=%b burst=%0d starve=%0d gnt=%b%b expected 0 0 0 10", b_rvalid, dut.burst_q, dut.starve_q, a_gnt, b_gnt); end
        tick();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 0 || b_rvalid !== 0)
            begin errors++; $display("FAIL rib_no_rvalid: got %b%b expected 00", a_rvalid, b_rvalid); end
        reset = 0;
        idle();
        tick();
    endtask

    task automatic test_idle;
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt, a_rvalid, b_rvalid, m_read, m_write} !== 6'b0 || m_addr !== 0 || m_wdata !== 0)
                begin errors++; $display("FAIL idle c=%0d: got gnt=%b%b rv=%b%b rd=%b wr=%b addr=%h wd=%h expected all zero", c, a_gnt, b_gnt, a_rvalid, b_rvalid, m_read, m_write, m_addr, m_wdata); end
            tick();
        end
    endtask

    task automatic test_random;
        int refused = 0, beats = 0;
        bit owed = 0, owed_n, ea, eb, ew, er;
        bit exp_arv = 0, exp_brv = 0;
        logic [15:0] exp_ard = 0, exp_brd = 0, eaddr, ewd;
        idle();
        reset = 1;
        tick();
        reset = 0;
        for (int c = 0; c < 600; c++) begin
            if (!a_req && $urandom_range(0, 3) != 0) begin
                a_req = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = 16'($urandom_range(0, 15) * 2); a_wdata = 16'($urandom);
            end
            if (!b_req && $urandom_range(0, 3) != 0) begin
                b_req = 1; b_we = 1'($urandom_range(0, 1)); b_lock = ($urandom_range(0, 3) != 0);
                b_addr = 16'($urandom_range(0, 15) * 2); b_wdata = 16'($urandom);
            end
            @(negedge clk);
            eb = (beats > 0) ? b_req : b_req && (!a_req || (refused >= MAX_WAIT && !owed));
            ea = (beats == 0) && a_req && !eb;
            ew = ea ? a_we : eb ? b_we : 1'b0;
            er = (ea && !a_we) || (eb && !b_we);
            eaddr = ea ? a_addr : eb ? b_addr : 16'h0;
            ewd = ea ? a_wdata : eb ? b_wdata : 16'h0;
            checks++;
            if ({a_gnt, b_gnt} !== {ea, eb})
                begin errors++; $display("FAIL rand_gnt c=%0d: got %b%b expected %b%b", c, a_gnt, b_gnt, ea, eb); end
            checks++;
            if (a_rvalid !== exp_arv || b_rvalid !== exp_brv || a_rdata !== exp_ard || b_rdata !== exp_brd)
                begin errors++; $display("FAIL rand_ret c=%0d: got rv=%b%b rd=%h/%h expected %b%b %h/%h", c, a_rvalid, b_rvalid, a_rdata, b_rdata, exp_arv, exp_brv, exp_ard, exp_brd); end
            checks++;
            if ({m_write, m_read, m_addr, m_wdata} !== {ew, er, eaddr, ewd})
                begin errors++; $display("FAIL rand_bus c=%0d: got wr=%b rd=%b addr=%h wd=%h expected %b %b %h %h", c, m_write, m_read, m_addr, m_wdata, ew, er, eaddr, ewd); end
            exp_arv = ea && !a_we;
            exp_brv = eb && !b_we;
            if (exp_arv) exp_ard = ref_mem[a_addr[8:1]];
            if (exp_brv) exp_brd = ref_mem[b_addr[8:1]];
            if (ea && a_we) ref_mem[a_addr[8:1]] = a_wdata;
            if (eb && b_we) ref_mem[b_addr[8:1]] = b_wdata;
            owed_n = 0;
            if (beats > 0) begin
                if (!b_req || !b_lock) beats = 0;
                else if (beats + 1 == BURST_MAX) begin beats = 0; owed_n = 1; end
                else beats++;
            end else if (eb && b_lock) beats = 1;
            owed = owed_n;
            refused = (b_req && !eb) ? ((refused + 1 > MAX_WAIT) ? MAX_WAIT : refused + 1) : 0;
            tick();
            if (ea) a_req = 0;
            if (eb) b_req = 0;
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_burst();
        test_reset_in_burst();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
